seven_seg_scanner: RTL and testbench
====================================

// Module: seven_seg_scanner
// PURPOSE
//  Time-multiplexed driver for an N-digit common-anode seven-segment display.
//  Captures a packed hex word, rotates one active anode per slot, decodes each nibble
//  to segments, and adds decimal points, per-digit enable, leading-zero blanking and
//  PWM brightness. Sits between the ALU result/opcode registers and the board display pins.
// PARAMETERS
//  NUM_DIGITS  4       number of digits scanned (>=2)
//  CLK_DIV     100000  clk cycles per digit slot (>=4)
//  BRIGHT_W    4       brightness control width
//  ACTIVE_LOW  1       1: anode/segs/dp_out driven active-low (board default); 0: active-high
// PORTS
//  clk         in   1             system clock, all logic rising-edge
//  rst_n       in   1             synchronous reset, active-low
//  data        in   4*NUM_DIGITS  nibble i = digit i; digit 0 is rightmost/least significant
//  dp_in       in   NUM_DIGITS    decimal point request per digit
//  digit_en    in   NUM_DIGITS    1 = digit shown; 0 = digit blank, anode never asserted
//  blank_lz    in   1             1 = suppress leading zeros
//  brightness  in   BRIGHT_W      duty level; all-ones = full on
//  load        in   1             request capture of data/dp_in at next frame boundary
//  anode       out  NUM_DIGITS    one-hot (per polarity) digit select
//  segs        out  7             {g,f,e,d,c,b,a}
//  dp_out      out  1             decimal point segment
//  frame_done  out  1             1-cycle pulse when last digit slot ends
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): prescaler=0, idx=0, shadow data/dp=0, pending=0;
//   anode/segs/dp_out all inactive (all 1s if ACTIVE_LOW), frame_done=0. Takes effect
//   the edge reset is sampled, including mid-slot or mid-frame; no partial slot resumes.
//  Prescaler: counts 0..CLK_DIV-1, wraps to 0. At wrap, idx advances; idx NUM_DIGITS-1
//   wraps to 0 and frame_done pulses in that same cycle.
//  Capture: load=1 sets pending (sticky). At a frame wrap with pending=1 (or load=1 that
//   cycle), shadow <= data/dp_in and pending clears; the new frame shows the new value.
//   No tearing: a frame always shows one snapshot. load held high = capture every frame.
//  digit_en, blank_lz, brightness are sampled live (not shadowed).
//  Decode (active-high internal, gfedcba): 0=0111111 1=0000110 2=1011011 3=1001111
//   4=1100110 5=1101101 6=1111101 7=0000111 8=1111111 9=1101111 A=1110111 b=1111100
//   C=0111001 d=1011110 E=1111001 F=1110001. Inverted on output when ACTIVE_LOW=1.
//  Leading-zero blanking: when blank_lz=1, digit i is blank if shadow nibbles i..N-1 are
//   all zero and i!=0; digit 0 is never LZ-blanked. dp of a blanked digit is also off.
//  Brightness: on_time = ((brightness+1)*CLK_DIV) >> BRIGHT_W. Anode idx active only
//   while prescaler < on_time; all-ones brightness = active whole slot. on_time=0 -> dark.
//  Blank digit (disabled, LZ, or PWM-off): anode inactive, segs and dp_out inactive.
//  Outputs registered: anode/segs/dp_out reflect idx/prescaler of previous cycle
//   (1-cycle latency). Never more than one anode active; segs never change while the
//   anode is active except at slot boundaries.
// TESTING  (NUM_DIGITS=4, CLK_DIV=8, BRIGHT_W=4, ACTIVE_LOW=1)
//  1 reset: rst_n=0 for 3 cycles -> anode=4'b1111, segs=7'h7F, dp_out=1, frame_done=0;
//    release -> anode=4'b1110 one cycle later, each digit active 8 cycles, frame_done every 32.
//  2 decode: data=16'h3A7F, load pulse, brightness=4'hF -> after frame wrap slots show
//    segs 0001110(F), 1111000(7), 0001000(A), 0110000(3) on anodes 1110,1101,1011,0111.
//  3 capture: change data mid-frame with load -> old value for remainder of frame, new value
//    from first slot after frame_done; data change without load -> no display change.
//  4 blanking: data=16'h0050, blank_lz=1 -> digits 3,2 anode inactive, digit1='5', digit0='0';
//    data=16'h0000 -> only digit 0 lit '0'; digit_en=4'b1011 -> digit 2 never asserted.
//  5 brightness: brightness=4'h7 -> on_time=4, anode active 4 of 8 cycles; 4'h0 -> dark.
//  6 reset mid-slot: assert rst_n=0 at idx=2, prescaler=5 -> all inactive next edge;
//    release -> scanning restarts at digit 0 with shadow=0.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode seven-segment driver: frame-synchronous capture of a hex word,
// per-slot anode rotation, hex decode, leading-zero blanking, dp and PWM brightness.
module seven_seg_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 100000,
    parameter int BRIGHT_W   = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              segs,
    output logic                    dp_out,
    output logic                    frame_done
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int OW = BRIGHT_W + PW + 2;

    localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [6:0]            SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = ACTIVE_LOW;

    logic [PW-1:0]                presc;
    logic [IW-1:0]                idx;
    logic [NUM_DIGITS-1:0][3:0]   shadow;
    logic [NUM_DIGITS-1:0]        shadow_dp;
    logic                         pending;

    logic                         slot_end;
    logic                         frame_end;
    logic [NUM_DIGITS-1:0]        lz_mask;
    logic [OW-1:0]                on_time;
    logic                         lit;
    logic [3:0]                   nib;
    logic [6:0]                   seg_on;
    logic [NUM_DIGITS-1:0]        onehot;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0: hex_decode = 7'h3F;
            4'h1: hex_decode = 7'h06;
            4'h2: hex_decode = 7'h5B;
            4'h3: hex_decode = 7'h4F;
            4'h4: hex_decode = 7'h66;
            4'h5: hex_decode = 7'h6D;
            4'h6: hex_decode = 7'h7D;
            4'h7: hex_decode = 7'h07;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h6F;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h7C;
            4'hC: hex_decode = 7'h39;
            4'hD: hex_decode = 7'h5E;
            4'hE: hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    assign slot_end  = (presc == PW'(CLK_DIV - 1));
    assign frame_end = slot_end && (idx == IW'(NUM_DIGITS - 1));

    // Digit i is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        lz_mask = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            lz_mask[i] = blank_lz;
            for (int j = i; j < NUM_DIGITS; j++)
                if (shadow[j] != 4'h0) lz_mask[i] = 1'b0;
        end
    end

    // All-ones brightness gives on_time == CLK_DIV, i.e. lit for the whole slot.
    assign on_time = ((OW'(brightness) + OW'(1)) * OW'(CLK_DIV)) >> BRIGHT_W;

    assign nib    = shadow[idx];
    assign seg_on = hex_decode(nib);
    assign onehot = NUM_DIGITS'(1) << idx;
    assign lit    = digit_en[idx] && !lz_mask[idx] && (OW'(presc) < on_time);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc      <= '0;
            idx        <= '0;
            shadow     <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            anode      <= AN_OFF;
            segs       <= SEG_OFF;
            dp_out     <= DP_OFF;
            frame_done <= 1'b0;
        end else begin
            presc <= slot_end ? '0 : presc + 1'b1;
            if (slot_end)
                idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            frame_done <= frame_end;

            // Shadow only moves at a frame wrap so a frame never mixes two snapshots.
            if (frame_end && (pending || load)) begin
                shadow    <= data;
                shadow_dp <= dp_in;
                pending   <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end

            anode  <= (lit ? onehot : '0) ^ AN_OFF;
            segs   <= (lit ? seg_on : 7'h00) ^ SEG_OFF;
            dp_out <= (lit && shadow_dp[idx]) ^ DP_OFF;
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: per-frame expectations are queued up front
// from the display rules, then popped and compared cycle by cycle.
module tb_seven_seg_scanner;
    localparam int N  = 4;
    localparam int CD = 8;
    localparam int BW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        blank_lz;
    logic [3:0]  brightness;
    logic        load;
    logic [3:0]  anode;
    logic [6:0]  segs;
    logic        dp_out;
    logic        frame_done;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .NUM_DIGITS(N), .CLK_DIV(CD), .BRIGHT_W(BW), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .dp_in(dp_in), .digit_en(digit_en),
        .blank_lz(blank_lz), .brightness(brightness), .load(load),
        .anode(anode), .segs(segs), .dp_out(dp_out), .frame_done(frame_done)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] sg;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] sh_data;
    logic [3:0]  sh_dp;
    logic [6:0]  dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag, input int i);
        exp_t e;
        exp_t got;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s[%0d] scoreboard empty got=0 required=1", tag, i);
            return;
        end
        e   = sb.pop_front();
        got = {anode, segs, dp_out, frame_done};
        checks++;
        assert ({got.an, got.sg, got.dp} === {e.an, e.sg, e.dp}) else begin
            failures++;
            $error("FAIL %s[%0d] pins got an=%b sg=%b dp=%b required an=%b sg=%b dp=%b",
                   tag, i, got.an, got.sg, got.dp, e.an, e.sg, e.dp);
        end
        checks++;
        assert (got.fd === e.fd) else begin
            failures++;
            $error("FAIL %s[%0d] frame_done got=%b required=%b", tag, i, got.fd, e.fd);
        end
    endtask

    // One full frame from a frame boundary; optional mid-frame data change at tick act_at.
    task automatic run_frame(input string tag, input int act_at, input logic [15:0] nd,
                             input logic [3:0] ndp, input logic nload);
        logic pend;
        pend = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            int   d;
            int   p;
            int   ot;
            logic lzb;
            logic lit;
            exp_t e;
            d   = (i - 1) / CD;
            p   = (i - 1) % CD;
            ot  = ((int'(brightness) + 1) * CD) >> BW;
            lzb = blank_lz && (d != 0) && ((sh_data >> (4 * d)) == 16'h0);
            lit = digit_en[d] && !lzb && (p < ot);
            e.an = lit ? ~(4'b0001 << d) : 4'hF;
            e.sg = lit ? ~dec[sh_data[4*d +: 4]] : 7'h7F;
            e.dp = !(lit && sh_dp[d]);
            e.fd = (i == 32);
            sb.push_back(e);
        end
        for (int i = 1; i <= 32; i++) begin
            tick();
            pop_check(tag, i);
            if (act_at >= 0 && i == act_at) begin
                data  = nd;
                dp_in = ndp;
                load  = nload;
                if (nload) pend = 1'b1;
            end else if (act_at >= 0 && i == act_at + 1) begin
                load = 1'b0;
            end
        end
        if (pend) begin
            sh_data = nd;
            sh_dp   = ndp;
        end
    endtask

    initial begin
        exp_t rst_e;
        rst_e      = {4'hF, 7'h7F, 1'b1, 1'b0};
        rst_n      = 1'b0;
        data       = 16'h0;
        dp_in      = 4'h0;
        digit_en   = 4'hF;
        blank_lz   = 1'b0;
        brightness = 4'hF;
        load       = 1'b0;
        sh_data    = 16'h0;
        sh_dp      = 4'h0;

        sb.push_back(rst_e);
        tick(); tick(); tick();
        pop_check("reset", 0);
        rst_n = 1'b1;

        run_frame("reset_frame", 10, 16'h3A7F, 4'b0010, 1'b1);
        run_frame("decode", -1, 16'h0, 4'h0, 1'b0);
        run_frame("capture_old", 12, 16'h0050, 4'h0, 1'b1);
        blank_lz = 1'b1;
        run_frame("lz_0050_noload", 5, 16'h9999, 4'hF, 1'b0);
        run_frame("lz_stay", 3, 16'h0000, 4'h0, 1'b1);
        run_frame("lz_zero", -1, 16'h0, 4'h0, 1'b0);
        blank_lz = 1'b0;
        digit_en = 4'b1011;
        run_frame("en_mask", 2, 16'h8421, 4'b0001, 1'b1);
        digit_en   = 4'hF;
        brightness = 4'h7;
        run_frame("pwm7", -1, 16'h0, 4'h0, 1'b0);
        brightness = 4'h0;
        run_frame("pwm0", -1, 16'h0, 4'h0, 1'b0);
        brightness = 4'h1;
        run_frame("pwm1", -1, 16'h0, 4'h0, 1'b0);
        brightness = 4'hF;

        // Walk to idx=2, prescaler=5 with a pending load, then reset mid-slot.
        for (int i = 1; i <= 21; i++) begin
            tick();
            if (i == 3) begin
                data = 16'h1234;
                load = 1'b1;
            end else if (i == 4) begin
                load = 1'b0;
            end
        end
        rst_n = 1'b0;
        sb.push_back(rst_e);
        tick();
        pop_check("reset_mid", 0);
        rst_n   = 1'b1;
        sh_data = 16'h0;
        sh_dp   = 4'h0;
        run_frame("after_rst", -1, 16'h0, 4'h0, 1'b0);
        run_frame("after_rst2", -1, 16'h0, 4'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
